// File: rtl/i2s_apb_feeder.sv
// Purpose: moves TX stream samples into an I2S_top TXDATA register and drains RXDATA
//          into an RX stream, polling STATUS before every data access.
// Latency: poll->write 2 cycles, poll->m_valid 4 cycles; next poll 1 cycle after a write
//          or after the RX handshake.
// Backpressure: s_ready only in the WRITE access; m_valid/m_data are held until m_ready,
//          and no bus access is started while an RX word is waiting.
// Ports:
//   pclk, preset         clock, synchronous active-high reset
//   enable               run/stop; only checked between accesses
//   s_valid/s_ready/s_data   TX sample stream in
//   m_valid/m_ready/m_data   RX sample stream out
//   paddr/pwdata/pwrite/penable/prdata   APB master towards I2S_top
//   tx_count/rx_count    wrapping word counters; busy = not IDLE
module i2s_apb_feeder #(
    parameter logic [31:0] ADR_OFFSET = 32'h0,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic        penable,
    input  logic [31:0] prdata,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic        busy
);

    localparam logic [31:0] TXDATA_ADR = ADR_OFFSET + 32'h4;
    localparam logic [31:0] RXDATA_ADR = ADR_OFFSET + 32'h8;
    localparam logic [31:0] STATUS_ADR = ADR_OFFSET + 32'hC;
    localparam logic [7:0]  GAP_LAST   = 8'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_POLL_WAIT,
        S_WRITE,
        S_READ,
        S_RD_CAP,
        S_OUT_WAIT,
        S_GAP
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  gap_cnt, gap_cnt_nx;
    logic        last_wr, last_wr_nx;
    logic [15:0] tx_cnt_q, tx_cnt_nx;
    logic [15:0] rx_cnt_q, rx_cnt_nx;
    logic        m_valid_q, m_valid_nx;
    logic [31:0] m_data_q, m_data_nx;
    logic [31:0] paddr_q, pwdata_q;

    logic        acc_en;
    logic        acc_wr;
    logic [31:0] acc_adr;
    logic [31:0] acc_dat;
    logic        wr_ok;
    logic        rd_ok;

    // prdata holds the STATUS word only in POLL_WAIT; these are ignored elsewhere.
    assign wr_ok = s_valid & ~prdata[0];
    assign rd_ok = ~prdata[1];

    always_comb begin
        state_nx   = state;
        gap_cnt_nx = gap_cnt;
        last_wr_nx = last_wr;
        tx_cnt_nx  = tx_cnt_q;
        rx_cnt_nx  = rx_cnt_q;
        m_valid_nx = m_valid_q;
        m_data_nx  = m_data_q;
        acc_en     = 1'b0;
        acc_wr     = 1'b0;
        acc_adr    = paddr_q;
        acc_dat    = pwdata_q;

        case (state)
            S_IDLE: begin
                if (enable) state_nx = S_POLL;
            end
            S_POLL: begin
                acc_en   = 1'b1;
                acc_adr  = STATUS_ADR;
                state_nx = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                end else if (wr_ok && rd_ok) begin
                    // Alternate when both directions are possible.
                    state_nx = last_wr ? S_READ : S_WRITE;
                end else if (wr_ok) begin
                    state_nx = S_WRITE;
                end else if (rd_ok) begin
                    state_nx = S_READ;
                end else if (POLL_GAP == 0) begin
                    state_nx = S_POLL;
                end else begin
                    state_nx   = S_GAP;
                    gap_cnt_nx = 8'd0;
                end
            end
            S_WRITE: begin
                // Followed directly by the next poll: two single-cycle transfers
                // back to back, each complete on its own.
                acc_en     = 1'b1;
                acc_wr     = 1'b1;
                acc_adr    = TXDATA_ADR;
                acc_dat    = s_data;
                tx_cnt_nx  = tx_cnt_q + 16'd1;
                last_wr_nx = 1'b1;
                state_nx   = S_POLL;
            end
            S_READ: begin
                acc_en   = 1'b1;
                acc_adr  = RXDATA_ADR;
                state_nx = S_RD_CAP;
            end
            S_RD_CAP: begin
                m_data_nx  = prdata;
                m_valid_nx = 1'b1;
                last_wr_nx = 1'b0;
                state_nx   = S_OUT_WAIT;
            end
            S_OUT_WAIT: begin
                // enable is only honoured once the held word has been taken.
                if (m_valid_q && m_ready) begin
                    m_valid_nx = 1'b0;
                    rx_cnt_nx  = rx_cnt_q + 16'd1;
                    state_nx   = enable ? S_POLL : S_IDLE;
                end
            end
            S_GAP: begin
                if (!enable) begin
                    state_nx = S_IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_nx = S_POLL;
                end else begin
                    gap_cnt_nx = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= S_IDLE;
            gap_cnt   <= 8'd0;
            last_wr   <= 1'b0;
            tx_cnt_q  <= 16'd0;
            rx_cnt_q  <= 16'd0;
            m_valid_q <= 1'b0;
            m_data_q  <= 32'd0;
            paddr_q   <= 32'd0;
            pwdata_q  <= 32'd0;
        end else begin
            state     <= state_nx;
            gap_cnt   <= gap_cnt_nx;
            last_wr   <= last_wr_nx;
            tx_cnt_q  <= tx_cnt_nx;
            rx_cnt_q  <= rx_cnt_nx;
            m_valid_q <= m_valid_nx;
            m_data_q  <= m_data_nx;
            paddr_q   <= acc_adr;
            pwdata_q  <= acc_dat;
        end
    end

    // Strobes are masked by preset so an access in flight is dropped in the reset cycle.
    assign penable  = acc_en & ~preset;
    assign pwrite   = acc_wr & ~preset;
    assign s_ready  = acc_wr & ~preset;
    assign paddr    = acc_adr;
    assign pwdata   = acc_dat;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign tx_count = tx_cnt_q;
    assign rx_count = rx_cnt_q;
    assign busy     = (state != S_IDLE);

endmodule
